// File: rtl/univ_shift_counter_pkg.sv
// Shared constants for univ_shift_counter: mode encodings, mode width and the
// per-bit next-value select used by the bit slices.
package univ_shift_counter_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHUP    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHDN    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_LOAD    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_RING    = 3'd4;
    localparam logic [MODE_W-1:0] MODE_JOHNSON = 3'd5;

    // Next-value source for one register bit.
    typedef enum logic [1:0] {
        SelHold  = 2'd0,  // keep current value
        SelLower = 2'd1,  // take from the bit below (shift up)
        SelUpper = 2'd2,  // take from the bit above (shift down)
        SelLoad  = 2'd3   // take parallel load value
    } sel_e;

endpackage

// File: rtl/usc_bit_slice.sv
// One bit of the universal shift register: 4:1 next-value select feeding a flop
// with synchronous active-low reset.
module usc_bit_slice
    import univ_shift_counter_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  sel_e i_sel,
    input  logic i_lower,
    input  logic i_upper,
    input  logic i_load,
    output logic o_q
);

    logic r_q;
    logic w_d;

    // Next-value select.
    always_comb begin
        w_d = r_q;
        unique case (i_sel)
            SelHold:  w_d = r_q;
            SelLower: w_d = i_lower;
            SelUpper: w_d = i_upper;
            SelLoad:  w_d = i_load;
            default:  w_d = r_q;
        endcase
    end

    // State flop; reset sampled on the clock edge.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/univ_shift_counter.sv
// Parametrised universal shift register / ring / Johnson counter.
// Optional build macro: SHIFT_COUNTER_SELF_CORRECT_EN -- when defined, illegal
// ring (not one-hot) and Johnson (more than one bit boundary) states are forced
// back into the legal sequence instead of circulating.
module univ_shift_counter
    import univ_shift_counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_load_data,
    input  logic              i_ser_in_lo,
    input  logic              i_ser_in_hi,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_tc
);

    // Last state before wrap in both counting modes.
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_lower;
    logic [WIDTH-1:0] w_upper;
    logic [WIDTH-1:0] w_load_val;
    logic             w_lower0;
    sel_e             w_sel;

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    localparam int unsigned TW = WIDTH - 1;

    logic [TW-1:0] w_trans;
    logic          w_ring_legal;
    logic          w_john_legal;

    // Legality of the current state for the counting modes.
    always_comb begin
        w_trans      = w_q[WIDTH-2:0] ^ w_q[WIDTH-1:1];
        w_ring_legal = $onehot(w_q);
        // At most one neighbour boundary: clear-lowest-set-bit leaves zero.
        w_john_legal = ((w_trans & (w_trans - TW'(1))) == '0);
    end
`endif

    // Shared bit-select and boundary inputs for the slices.
    always_comb begin
        w_sel      = SelHold;
        w_lower0   = i_ser_in_lo;
        w_load_val = i_load_data;
        if (i_en) begin
            case (i_mode)
                MODE_HOLD: w_sel = SelHold;
                MODE_SHUP: w_sel = SelLower;
                MODE_SHDN: w_sel = SelUpper;
                MODE_LOAD: w_sel = SelLoad;
                MODE_RING: begin
                    w_sel    = SelLower;
                    w_lower0 = w_q[WIDTH-1];
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
                    if (!w_ring_legal) begin
                        w_sel      = SelLoad;
                        w_load_val = WIDTH'(1);
                    end
`endif
                end
                MODE_JOHNSON: begin
                    w_sel    = SelLower;
                    w_lower0 = ~w_q[WIDTH-1];
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
                    if (!w_john_legal) begin
                        w_sel      = SelLoad;
                        w_load_val = '0;
                    end
`endif
                end
                default: w_sel = SelHold;  // reserved modes hold
            endcase
        end
    end

    // Neighbour wiring: bit 0 gets serial/feedback, top bit gets ser_in_hi.
    always_comb begin
        w_lower = {w_q[WIDTH-2:0], w_lower0};
        w_upper = {i_ser_in_hi, w_q[WIDTH-1:1]};
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        usc_bit_slice #(
            .RST_VAL(RESET_VALUE[gi])
        ) u_slice (
            .i_clock(i_clock),
            .i_reset(i_reset),
            .i_sel  (w_sel),
            .i_lower(w_lower[gi]),
            .i_upper(w_upper[gi]),
            .i_load (w_load_val[gi]),
            .o_q    (w_q[gi])
        );
    end

    // Wrap indicator is combinational from current state and controls.
    always_comb begin
        o_q  = w_q;
        o_tc = i_en & ((i_mode == MODE_RING) | (i_mode == MODE_JOHNSON)) & (w_q == MSB_ONLY);
    end

endmodule

// File: tb/tb_univ_shift_counter.sv
// Directed self-checking bench for univ_shift_counter (WIDTH=4 and WIDTH=8 instances).
module tb_univ_shift_counter;
    import univ_shift_counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 DUT
    logic       rst4, en4, sil4, sih4;
    logic [2:0] mode4;
    logic [3:0] ld4, q4;
    logic       tc4;

    // WIDTH=8 DUT, RESET_VALUE=8'h01
    logic       rst8, en8, sil8, sih8;
    logic [2:0] mode8;
    logic [7:0] ld8, q8;
    logic       tc8;

    univ_shift_counter #(.WIDTH(4), .RESET_VALUE(4'h0)) u_dut4 (
        .i_clock(clk), .i_reset(rst4), .i_en(en4), .i_mode(mode4),
        .i_load_data(ld4), .i_ser_in_lo(sil4), .i_ser_in_hi(sih4),
        .o_q(q4), .o_tc(tc4)
    );

    univ_shift_counter #(.WIDTH(8), .RESET_VALUE(8'h01)) u_dut8 (
        .i_clock(clk), .i_reset(rst8), .i_en(en8), .i_mode(mode8),
        .i_load_data(ld8), .i_ser_in_lo(sil8), .i_ser_in_hi(sih8),
        .o_q(q8), .o_tc(tc8)
    );

`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    localparam logic [3:0] EXP_BAD_JOHN = 4'b0000;
    localparam logic [3:0] EXP_BAD_RING = 4'b0001;
    localparam logic [3:0] EXP_ZERO_RING = 4'b0001;
`else
    localparam logic [3:0] EXP_BAD_JOHN = 4'b1011;
    localparam logic [3:0] EXP_BAD_RING = 4'b1100;
    localparam logic [3:0] EXP_ZERO_RING = 4'b0000;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [3:0] ld;
        logic       sil;
        logic       sih;
        logic [3:0] exp_q;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tc_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic [2:0] mode,
                       input logic [3:0] ld, input logic sil, input logic sih,
                       input logic [3:0] exp_q, input logic exp_tc);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.ld = ld;
        v.sil = sil; v.sih = sih; v.exp_q = exp_q; v.exp_tc = exp_tc;
        vecs.push_back(v);
    endtask

    initial begin
        rst4 = 1'b0; en4 = 1'b0; mode4 = MODE_HOLD; ld4 = '0; sil4 = 1'b0; sih4 = 1'b0;
        rst8 = 1'b0; en8 = 1'b0; mode8 = MODE_HOLD; ld8 = '0; sil8 = 1'b0; sih8 = 1'b0;

        // Reset dominates en/mode; reserved mode holds.
        add(0, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0000, 0);
        add(0, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0000, 0);
        add(1, 1, 3'd6,         4'h0, 0, 0, 4'b0000, 0);
        // Full Johnson period from zero.
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0001, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0011, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0111, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1111, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1110, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1100, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1000, 1);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0000, 0);
        // en=0 freezes mid-sequence.
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0001, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0011, 0);
        add(1, 0, MODE_JOHNSON, 4'h0, 0, 0, 4'b0011, 0);
        add(1, 0, MODE_JOHNSON, 4'h0, 0, 0, 4'b0011, 0);
        add(1, 0, MODE_JOHNSON, 4'h0, 0, 0, 4'b0011, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b0111, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1111, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1110, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1100, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, 4'b1000, 1);
        add(1, 0, MODE_JOHNSON, 4'h0, 0, 0, 4'b1000, 0);  // tc gated by en
        // Load and shifts; reserved modes hold a nonzero value.
        add(1, 1, MODE_LOAD,    4'hA, 0, 0, 4'b1010, 0);
        add(1, 1, 3'd6,         4'h5, 1, 1, 4'b1010, 0);
        add(1, 1, 3'd7,         4'h5, 1, 1, 4'b1010, 0);
        add(1, 1, MODE_SHUP,    4'h0, 1, 0, 4'b0101, 0);
        add(1, 1, MODE_SHDN,    4'h0, 1, 0, 4'b0010, 0);
        add(1, 1, MODE_SHDN,    4'h0, 0, 1, 4'b1001, 0);
        add(1, 1, MODE_HOLD,    4'h0, 1, 1, 4'b1001, 0);
        // Ring from one-hot, then reset mid-sequence.
        add(1, 1, MODE_LOAD,    4'h1, 0, 0, 4'b0001, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b0010, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b0100, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b1000, 1);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b0001, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b0010, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, 4'b0100, 0);
        add(0, 1, MODE_RING,    4'h0, 0, 0, 4'b0000, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, EXP_ZERO_RING, 0);
        // tc stays low in LOAD even at the wrap pattern.
        add(1, 1, MODE_LOAD,    4'h8, 0, 0, 4'b1000, 0);
        add(1, 1, MODE_SHUP,    4'h0, 0, 0, 4'b0000, 0);
        // Illegal counting states.
        add(1, 1, MODE_LOAD,    4'h5, 0, 0, 4'b0101, 0);
        add(1, 1, MODE_JOHNSON, 4'h0, 0, 0, EXP_BAD_JOHN, 0);
        add(1, 1, MODE_LOAD,    4'h6, 0, 0, 4'b0110, 0);
        add(1, 1, MODE_RING,    4'h0, 0, 0, EXP_BAD_RING, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst4 = vecs[i].rst; en4 = vecs[i].en; mode4 = vecs[i].mode;
            ld4 = vecs[i].ld; sil4 = vecs[i].sil; sih4 = vecs[i].sih;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d q", i), 32'(q4), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d tc", i), 32'(tc4), 32'(vecs[i].exp_tc));
        end

        @(negedge clk);
        en4 = 1'b0;

        // WIDTH=8: reset to 01, then one full ring revolution.
        rst8 = 1'b0; en8 = 1'b1; mode8 = MODE_RING;
        @(posedge clk);
        #1;
        check("w8 reset q", 32'(q8), 32'h01);
        check("w8 reset tc", 32'(tc8), 32'h0);
        @(negedge clk);
        rst8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp_q;
            exp_q = 8'(1 << ((k + 1) % 8));
            @(posedge clk);
            #1;
            check($sformatf("w8 ring step%0d q", k), 32'(q8), 32'(exp_q));
            check($sformatf("w8 ring step%0d tc", k), 32'(tc8), 32'(exp_q == 8'h80));
            if (tc8) tc_seen++;
        end
        check("w8 tc count", 32'(tc_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
